// File: rtl/dmem_wbuf_unit_pkg.sv
// Shared types and helpers for the data-memory write-buffer block.
// Byte-lane geometry of a 64-bit doubleword lives here.
package dmem_wbuf_unit_pkg;

  localparam int DATA_W     = 64;
  localparam int LANES      = 8;
  localparam int LANE_W     = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 4;

  typedef logic [DATA_W-1:0] dword_t;
  typedef logic [LANES-1:0]  lane_mask_t;

  // Replace the lanes of old_d selected by mask with the same lanes of new_d.
  function automatic dword_t merge_bytes(dword_t old_d, dword_t new_d, lane_mask_t mask);
    dword_t r;
    r = old_d;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) r[i*LANE_W +: LANE_W] = new_d[i*LANE_W +: LANE_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_wbuf_unit_if.sv
// Pipeline-side bus of the data memory: EXE/MEM request in, load data and buffer status out.
interface dmem_wbuf_unit_if #(
  parameter int DEPTH = 4
);
  logic [31:0]              addr;
  logic [63:0]              wdata;
  logic                     wr_en;
  logic [7:0]               wmask;
  logic                     rd_en;
  logic [63:0]              rdata;
  logic [$clog2(DEPTH):0]   wb_count;
  logic                     wb_empty;

  modport master (
    output addr, wdata, wr_en, wmask, rd_en,
    input  rdata, wb_count, wb_empty
  );

  modport slave (
    input  addr, wdata, wr_en, wmask, rd_en,
    output rdata, wb_count, wb_empty
  );
endinterface

// File: rtl/dmem_wbuf_unit_wbuf_fifo.sv
// Posted-store FIFO: entry storage, head/tail/count, coalescing into the youngest entry and one drain per cycle.
// All entries are exported so the parent can build the forwarding overlay.
module wbuf_fifo
  import dmem_wbuf_unit_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [ADDR_W-1:0]              idx,
  input  dword_t                         wdata,
  input  lane_mask_t                     wmask,
  output logic [DEPTH-1:0]               ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]   ent_idx,
  output logic [DEPTH-1:0][DATA_W-1:0]   ent_data,
  output logic [DEPTH-1:0][LANES-1:0]    ent_mask,
  output logic [$clog2(DEPTH)-1:0]       head,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           drain,
  output logic [ADDR_W-1:0]              drain_idx,
  output dword_t                         drain_data,
  output lane_mask_t                     drain_mask
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] tail;
  logic [PW-1:0] tail_m1;
  logic          enq;
  logic          full;
  logic          coalesce;
  logic          append;

  always_comb begin
    enq      = wr_en && (wmask != '0);
    full     = (count == (PW+1)'(DEPTH));
    tail_m1  = tail - 1'b1;
    // A full buffer never stalls a store: the head is pushed out to make room.
    drain    = ((count != '0) && !rd_en) || (enq && full);
    // Never merge into the entry that is leaving for the array this cycle.
    coalesce = enq && (count != '0) && ent_valid[tail_m1] && (ent_idx[tail_m1] == idx)
               && !(drain && (tail_m1 == head));
    append   = enq && !coalesce;
  end

  assign drain_idx  = ent_idx[head];
  assign drain_data = ent_data[head];
  assign drain_mask = ent_mask[head];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      if (append) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      count <= count + (PW+1)'(append) - (PW+1)'(drain);
    end
  end

  // Payload needs no reset; the valid bits alone decide what is pending.
  always_ff @(posedge clk) begin
    if (append) begin
      ent_idx[tail]  <= idx;
      ent_data[tail] <= wdata;
      ent_mask[tail] <= wmask;
    end else if (coalesce) begin
      ent_data[tail_m1] <= merge_bytes(ent_data[tail_m1], wdata, wmask);
      ent_mask[tail_m1] <= ent_mask[tail_m1] | wmask;
    end
  end

endmodule

// File: rtl/dmem_wbuf_unit.sv
// Data memory behind EXE/MEM: single-ported doubleword array fed by a posted write buffer,
// with byte-granular forwarding of pending stores into same-cycle load data.
module dmem_wbuf_unit
  import dmem_wbuf_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  dmem_wbuf_unit_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0]              idx;
  logic [DEPTH-1:0]               ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0]   ent_idx;
  logic [DEPTH-1:0][DATA_W-1:0]   ent_data;
  logic [DEPTH-1:0][LANES-1:0]    ent_mask;
  logic [PW-1:0]                  head;
  logic [PW:0]                    count;
  logic                           drain;
  logic [ADDR_W-1:0]              drain_idx;
  dword_t                         drain_data;
  lane_mask_t                     drain_mask;
  dword_t                         rdata_c;
  logic [PW-1:0]                  slot;
  logic                           unused_addr;

  dword_t mem [2**ADDR_W];

  assign idx         = bus.addr[ADDR_W+2:3];
  assign unused_addr = ^{bus.addr[31:ADDR_W+3], bus.addr[2:0]};

  wbuf_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .nrst       (nrst),
    .wr_en      (bus.wr_en),
    .rd_en      (bus.rd_en),
    .idx        (idx),
    .wdata      (bus.wdata),
    .wmask      (bus.wmask),
    .ent_valid  (ent_valid),
    .ent_idx    (ent_idx),
    .ent_data   (ent_data),
    .ent_mask   (ent_mask),
    .head       (head),
    .count      (count),
    .drain      (drain),
    .drain_idx  (drain_idx),
    .drain_data (drain_data),
    .drain_mask (drain_mask)
  );

  always_ff @(posedge clk) begin
    if (drain) mem[drain_idx] <= merge_bytes(mem[drain_idx], drain_data, drain_mask);
  end

  // Walk entries oldest to youngest so the youngest store owns each lane.
  always_comb begin
    rdata_c = '0;
    slot    = '0;
    if (bus.rd_en) begin
      rdata_c = mem[idx];
      for (int k = 0; k < DEPTH; k++) begin
        slot = head + PW'(k);
        if (ent_valid[slot] && (ent_idx[slot] == idx)) begin
          rdata_c = merge_bytes(rdata_c, ent_data[slot], ent_mask[slot]);
        end
      end
    end
  end

  assign bus.rdata    = rdata_c;
  assign bus.wb_count = count;
  assign bus.wb_empty = (count == '0);

endmodule
